ifetch_responder: RTL

//   Memory-side responder for the pipeline's instruction-fetch port A; answers read_a/address_a with resp_a/rdata_a.

---
 rtl/ifetch_responder_pkg.sv | 15 +
 rtl/ifetch_responder_if.sv | 26 ++
 rtl/ifetch_responder_line_store.sv | 46 ++++
 rtl/ifetch_responder.sv | 116 +++++++++++
 4 files changed

// File: rtl/ifetch_responder_pkg.sv
// Shared types for the instruction-fetch responder: the 16-bit machine word,
// the 128-bit cache line, and the responder FSM state encoding.
package ifetch_responder_pkg;

  localparam int DEFAULT_OFFSET_BITS = 4;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } ifr_state_t;

endpackage

// File: rtl/ifetch_responder_if.sv
// Bundle of the fetch-port and physical-memory signals around the responder.
// The slave modport is the responder's view; master is the surrounding system.
interface ifetch_responder_if;
  import ifetch_responder_pkg::*;

  logic     read_a;
  lc3b_word address_a;
  logic     flush;
  logic     resp_a;
  lc3b_word rdata_a;
  logic     pmem_read;
  lc3b_word pmem_address;
  logic     pmem_resp;
  lc3b_line pmem_rdata;

  modport slave (
    input  read_a, address_a, flush, pmem_resp, pmem_rdata,
    output resp_a, rdata_a, pmem_read, pmem_address
  );

  modport master (
    output read_a, address_a, flush, pmem_resp, pmem_rdata,
    input  resp_a, rdata_a, pmem_read, pmem_address
  );

endinterface

// File: rtl/ifetch_responder_line_store.sv
// Single-line buffer for the fetch responder: holds valid/tag/line, selects
// the addressed word and reports a hit. A flush blocks the hit in the same
// cycle and clears valid on the next edge unless a fill lands at that edge.
module ifr_line_store
  import ifetch_responder_pkg::*;
#(
  parameter int OFFSET_BITS = DEFAULT_OFFSET_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fillEn,
  input  logic                   fillValid,
  input  logic [15:OFFSET_BITS]  fillTag,
  input  lc3b_line               fillLine,
  input  logic                   read_a,
  input  logic                   flush,
  input  logic [15:1]            addrWord,
  output logic                   hit,
  output lc3b_word               rdata
);

  logic                  valid_q;
  logic [15:OFFSET_BITS] tag_q;
  lc3b_line              line_q;
  logic [OFFSET_BITS-2:0] wordSel;

  // Line registers: a fill overwrites everything, a lone flush only drops valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      line_q  <= '0;
    end else if (fillEn) begin
      valid_q <= fillValid;
      tag_q   <= fillTag;
      line_q  <= fillLine;
    end else if (flush) begin
      valid_q <= 1'b0;
    end
  end

  assign wordSel = addrWord[OFFSET_BITS-1:1];
  assign hit     = read_a & valid_q & (tag_q == addrWord[15:OFFSET_BITS]) & ~flush;
  assign rdata   = valid_q ? line_q[{wordSel, 4'b0000} +: 16] : '0;

endmodule

// File: rtl/ifetch_responder.sv
// Memory-side responder for instruction-fetch port A. Hits answer in the same
// cycle from a one-line buffer; misses stall while the line is read from
// physical memory. Fills are never aborted; a flush during a fill marks it
// to be discarded so the line gets fetched again if still wanted.
// Optional build macro IFETCH_RESPONDER_STATS_EN adds saturating
// hit_count/miss_count outputs.
module ifetch_responder
  import ifetch_responder_pkg::*;
#(
  parameter int OFFSET_BITS = DEFAULT_OFFSET_BITS
) (
  input  logic clk,
  input  logic reset,
  ifetch_responder_if.slave bus
`ifdef IFETCH_RESPONDER_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  ifr_state_t state_q, state_d;
  logic       drop_q, drop_d;
  lc3b_word   pmemAddress_q, pmemAddress_d;
  logic       fillEn;
  logic       startFetch;
  logic       respA;
  logic       hit;
  lc3b_word   rdata;

  ifr_line_store #(.OFFSET_BITS(OFFSET_BITS)) lineStore (
    .clk       (clk),
    .reset     (reset),
    .fillEn    (fillEn),
    .fillValid (~drop_q & ~bus.flush),
    .fillTag   (pmemAddress_q[15:OFFSET_BITS]),
    .fillLine  (bus.pmem_rdata),
    .read_a    (bus.read_a),
    .flush     (bus.flush),
    .addrWord  (bus.address_a[15:1]),
    .hit       (hit),
    .rdata     (rdata)
  );

  // State, discard flag and line-address registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      drop_q        <= 1'b0;
      pmemAddress_q <= '0;
    end else begin
      state_q       <= state_d;
      drop_q        <= drop_d;
      pmemAddress_q <= pmemAddress_d;
    end
  end

  // Next-state logic: start a line read on a miss, finish it on pmem_resp.
  always_comb begin
    state_d       = state_q;
    drop_d        = drop_q;
    pmemAddress_d = pmemAddress_q;
    fillEn        = 1'b0;
    startFetch    = 1'b0;
    respA         = 1'b0;
    case (state_q)
      IDLE: begin
        respA = hit;
        if (bus.read_a && !hit && !bus.flush) begin
          startFetch    = 1'b1;
          pmemAddress_d = {bus.address_a[15:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          state_d       = FETCH;
        end
      end
      FETCH: begin
        if (bus.flush) begin
          drop_d = 1'b1;
        end
        if (bus.pmem_resp) begin
          fillEn  = 1'b1;
          drop_d  = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
  end

  assign bus.resp_a       = respA;
  assign bus.rdata_a      = rdata;
  assign bus.pmem_read    = (state_q == FETCH);
  assign bus.pmem_address = pmemAddress_q;

`ifdef IFETCH_RESPONDER_STATS_EN
  logic [15:0] hitCount_q;
  logic [15:0] missCount_q;

  // Saturating counters of answered requests and started line reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      hitCount_q  <= '0;
      missCount_q <= '0;
    end else begin
      if (respA && hitCount_q != 16'hFFFF) begin
        hitCount_q <= hitCount_q + 16'd1;
      end
      if (startFetch && missCount_q != 16'hFFFF) begin
        missCount_q <= missCount_q + 16'd1;
      end
    end
  end

  assign hit_count  = hitCount_q;
  assign miss_count = missCount_q;
`endif

endmodule
